// File: rtl/gf8_mul_sched.sv
// gf8_mul_sched: two-requester GF(2^8) multiplier (carry-less multiply, then bit-serial reduction); define GF8_SCHED_FIXED_PRIO_EN for fixed-priority arbitration
module gf8_mul_sched #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_y,
  output logic        out_id,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, RED, DONE} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_a, r_b;
  logic        r_id;
  logic [2:0]  r_cnt;
  logic [14:0] r_p, w_clmul, w_red;
  logic        w_gnt_id, w_accept;
  logic [1:0]  w_ready;
`ifndef GF8_SCHED_FIXED_PRIO_EN
  logic        r_ptr;
`endif
  // pick the requester to serve; a lone valid requester always wins, ready only for a valid one
  always_comb begin
`ifdef GF8_SCHED_FIXED_PRIO_EN
    w_gnt_id = ~req_valid[0];
`else
    w_gnt_id = (&req_valid) ? r_ptr : req_valid[1];
`endif
    w_ready  = (r_state == IDLE && req_valid[w_gnt_id]) ? (2'b01 << w_gnt_id) : 2'b00;
    w_accept = |w_ready;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_accept ? MUL : IDLE;
      MUL:     w_next = RED;
      RED:     w_next = (r_cnt == 3'd0) ? DONE : RED;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // carry-less 8x8 product of the latched operands
  always_comb begin
    w_clmul = '0;
    for (int i = 0; i < 8; i++)
      if (r_a[i]) w_clmul ^= 15'(r_b) << i;
  end
  // one reduction step: if p[8+n] is set, XOR x^8+POLY aligned at bit n, clearing p[8+n]
  always_comb begin
    w_red = r_p[{1'b1, r_cnt}] ? (r_p ^ (15'({1'b1, POLY}) << r_cnt)) : r_p;
  end
  // operand capture, product register and reduction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_id  <= 1'b0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= w_gnt_id ? req_a[15:8] : req_a[7:0];
        r_b  <= w_gnt_id ? req_b[15:8] : req_b[7:0];
        r_id <= w_gnt_id;
      end
      if (r_state == MUL) begin
        r_p   <= w_clmul;
        r_cnt <= 3'd6;
      end
      if (r_state == RED) begin
        r_p   <= w_red;
        r_cnt <= (r_cnt != 3'd0) ? r_cnt - 3'd1 : r_cnt;
      end
    end
  end
`ifndef GF8_SCHED_FIXED_PRIO_EN
  // round-robin pointer hands priority to the requester not just served
  always_ff @(posedge clk) begin
    if (!rst_n)        r_ptr <= 1'b0;
    else if (w_accept) r_ptr <= ~w_gnt_id;
  end
`endif
  assign req_ready = w_ready;
  assign out_valid = (r_state == DONE);
  assign out_y     = r_p[7:0];
  assign out_id    = r_id;
  assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_gf8_mul_sched.sv
// tb_gf8_mul_sched: randomized and directed checks of gf8_mul_sched against a behavioural model
module tb_gf8_mul_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req_a = '0, req_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_y;
  logic        out_id;
  logic        busy;

  gf8_mul_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // shift-and-add GF(2^8) multiply with xtime
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) y ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    end
    return y;
  endfunction

  bit         m_known = 0;
  bit         m_busy = 0;
  bit         m_ptr = 0;
  int         m_age = 0;
  logic [7:0] m_y = '0;
  logic       m_id = 1'b0;

  function automatic logic [1:0] m_grant();
    if (m_busy) return 2'b00;
    if (req_valid == 2'b11) begin
`ifdef GF8_SCHED_FIXED_PRIO_EN
      return 2'b01;
`else
      return m_ptr ? 2'b10 : 2'b01;
`endif
    end
    return req_valid;
  endfunction

  // model: result ready 9 cycles after accept, held until taken
  always @(posedge clk) begin : model
    logic [1:0] g;
    g = m_grant();
    if (!rst_n) begin
      m_known = 1; m_busy = 0; m_ptr = 0; m_age = 0;
    end else if (m_known) begin
      if (g != 2'b00) begin
        m_id   = g[1];
        m_y    = gf_mul(g[1] ? req_a[15:8] : req_a[7:0], g[1] ? req_b[15:8] : req_b[7:0]);
        m_busy = 1; m_age = 1; m_ptr = ~g[1];
      end else if (m_busy) begin
        if (m_age >= 9 && out_ready) m_busy = 0;
        else m_age++;
      end
    end
  end

  // compare DUT outputs to the model every cycle
  always @(negedge clk) begin
    if (m_known) begin
      chk("req_ready", 16'(req_ready), 16'(m_grant()));
      chk("busy", 16'(busy), 16'(m_busy));
      chk("out_valid", 16'(out_valid), 16'(m_busy && m_age >= 9));
      if (m_busy && m_age >= 9) begin
        chk("out_y", 16'(out_y), 16'(m_y));
        chk("out_id", 16'(out_id), 16'(m_id));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] y, output logic yid, output int lat);
    int k;
    if (id == 1) begin req_a[15:8] = a; req_b[15:8] = b; end
    else begin req_a[7:0] = a; req_b[7:0] = b; end
    req_valid[id] = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[id]) break;
      @(posedge clk); #1;
    end
    if (k == 50) chk("accept timeout", 16'(k), 16'(0));
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    lat = 1;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    y = out_y;
    yid = out_id;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] y, y0;
    logic       yid, id0;
    int         lat, cnt, seen;
    logic [1:0] seq [4];
    chk("model 57*83", 16'(gf_mul(8'h57, 8'h83)), 16'h00C1);
    chk("model 53*CA", 16'(gf_mul(8'h53, 8'hCA)), 16'h0001);
    chk("model 02*80", 16'(gf_mul(8'h02, 8'h80)), 16'h001B);
    chk("model 00*FF", 16'(gf_mul(8'h00, 8'hFF)), 16'h0000);
    out_ready = 1'b1;
    rst_n = 1'b0;
    step(3);
    chk("rst req_ready", 16'(req_ready), 16'h0);
    chk("rst out_valid", 16'(out_valid), 16'h0);
    chk("rst out_y", 16'(out_y), 16'h0);
    chk("rst out_id", 16'(out_id), 16'h0);
    chk("rst busy", 16'(busy), 16'h0);
    rst_n = 1'b1;
    step(1);
    run_op(0, 8'h57, 8'h83, y, yid, lat);
    chk("57*83 y", 16'(y), 16'h00C1);
    chk("57*83 id", 16'(yid), 16'h0);
    chk("57*83 latency", 16'(lat), 16'd9);
    run_op(1, 8'h53, 8'hCA, y, yid, lat);
    chk("53*CA y", 16'(y), 16'h0001);
    chk("53*CA id", 16'(yid), 16'h1);
    run_op(1, 8'h02, 8'h80, y, yid, lat);
    chk("02*80 y", 16'(y), 16'h001B);
    run_op(0, 8'h00, 8'hFF, y, yid, lat);
    chk("00*FF y", 16'(y), 16'h0000);
    chk("00*FF latency", 16'(lat), 16'd9);
    // contention from a fresh pointer
    do_reset();
    req_a = 16'h1234; req_b = 16'hA5C3; req_valid = 2'b11;
    cnt = 0;
    for (int k = 0; k < 80 && cnt < 4; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin seq[cnt] = req_ready; cnt++; end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    chk("contention grants", 16'(cnt), 16'd4);
`ifdef GF8_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) chk("fixed grant", 16'(seq[k]), 16'h1);
`else
    for (int k = 0; k < 4; k++) chk("rr grant", 16'(seq[k]), (k % 2) ? 16'h2 : 16'h1);
`endif
    step(12);
    // backpressure held in DONE
    out_ready = 1'b0;
    req_a[7:0] = 8'hC7; req_b[7:0] = 8'h3D; req_valid = 2'b01;
    for (int k = 0; k < 40 && !out_valid; k++) begin
      @(posedge clk); #1;
      req_valid = 2'b11;
    end
    chk("bp reached done", 16'(out_valid), 16'h1);
    y0 = out_y; id0 = out_id;
    chk("bp value", 16'(y0), 16'(gf_mul(8'hC7, 8'h3D)));
    chk("bp id", 16'(id0), 16'h0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp hold y", 16'(out_y), 16'(y0));
      chk("bp hold id", 16'(out_id), 16'(id0));
      chk("bp ready", 16'(req_ready), 16'h0);
      @(posedge clk); #1;
    end
    req_valid = 2'b00; out_ready = 1'b1;
    step(1);
    chk("bp single result", 16'(out_valid), 16'h0);
    step(2);
    // reset in the 4th reduction cycle
    req_a[7:0] = 8'h57; req_b[7:0] = 8'h83; req_valid = 2'b01;
    for (int k = 0; k < 20 && !req_ready[0]; k++) begin @(posedge clk); #1; end
    step(1);
    req_valid = 2'b00;
    step(4);
    rst_n = 1'b0;
    step(1);
    chk("abort busy", 16'(busy), 16'h0);
    chk("abort out_valid", 16'(out_valid), 16'h0);
    chk("abort out_y", 16'(out_y), 16'h0);
    chk("abort out_id", 16'(out_id), 16'h0);
    chk("abort req_ready", 16'(req_ready), 16'h0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("abort no result", 16'(seen), 16'h0);
    run_op(1, 8'h02, 8'h80, y, yid, lat);
    chk("after abort y", 16'(y), 16'h001B);
    chk("after abort latency", 16'(lat), 16'd9);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      req_valid = 2'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      step(1);
    end
    rst_n = 1'b1; req_valid = 2'b00;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
